// File: rtl/tdm_demux4.sv
// Receive end of a 4:1 TDM link: rebuilds 4-bit words from a serial line using a free-running slot counter.
// Word and valid/realign pulses are registered one edge after the last sample; en=0 stalls the frame in place.
module tdm_demux4 #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sync,
    input  logic       F,
    output logic [1:0] S,
    output logic [3:0] w,
    output logic       valid,
    output logic       realign
);

    logic [1:0] slot_q, slot_d;
    logic [3:0] sh_q, sh_d;
    logic [3:0] w_q, w_d;
    logic       valid_q, valid_d;
    logic       realign_q, realign_d;

    logic       sync_hit;
    logic [3:0] slot_oh;

    assign sync_hit = (SYNC_EN == 1'b1) && sync;
    assign slot_oh  = 4'b0001 << slot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q    <= 2'd0;
            sh_q      <= 4'd0;
            w_q       <= 4'd0;
            valid_q   <= 1'b0;
            realign_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            sh_q      <= sh_d;
            w_q       <= w_d;
            valid_q   <= valid_d;
            realign_q <= realign_d;
        end
    end

    always_comb begin
        slot_d    = slot_q;
        sh_d      = sh_q;
        w_d       = w_q;
        valid_d   = 1'b0;
        realign_d = 1'b0;
        if (en) begin
            if (sync_hit) begin
                // Sync wins over completion: the partial frame is dropped, the current bit becomes slot 0.
                sh_d      = {sh_q[3:1], F};
                slot_d    = 2'd1;
                realign_d = (slot_q != 2'd0);
            end else begin
                sh_d   = (sh_q & ~slot_oh) | ({4{F}} & slot_oh);
                slot_d = slot_q + 2'd1;
                if (slot_q == 2'd3) begin
                    w_d     = {F, sh_q[2:0]};
                    valid_d = 1'b1;
                end
            end
        end
    end

    assign S       = slot_q;
    assign w       = w_q;
    assign valid   = valid_q;
    assign realign = realign_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed vector table, async reset sequence, and random traffic vs. a frame-level model.
module tb_tdm_demux4;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sync;
    logic       F;
    logic [1:0] S_a, S_b;
    logic [3:0] w_a, w_b;
    logic       valid_a, valid_b;
    logic       realign_a, realign_b;

    int n_pass;
    int n_total;

    tdm_demux4 #(.SYNC_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .F(F),
        .S(S_a), .w(w_a), .valid(valid_a), .realign(realign_a)
    );

    tdm_demux4 #(.SYNC_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .F(F),
        .S(S_b), .w(w_b), .valid(valid_b), .realign(realign_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 honours sync, index 1 ignores it.
    int         m_slot    [2];
    bit         m_bits    [2][4];
    logic [3:0] m_w       [2];
    bit         m_valid   [2];
    bit         m_realign [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_slot[i] = 0;
            for (int k = 0; k < 4; k++) m_bits[i][k] = 1'b0;
            m_w[i] = 4'd0;
            m_valid[i] = 1'b0;
            m_realign[i] = 1'b0;
        end
    endfunction

    function automatic void model_step(int i, bit e, bit s, bit f);
        m_valid[i] = 1'b0;
        m_realign[i] = 1'b0;
        if (!e) return;
        if (s && i == 0) begin
            m_realign[i] = (m_slot[i] != 0);
            m_bits[i][0] = f;
            m_slot[i] = 1;
        end else begin
            m_bits[i][m_slot[i]] = f;
            if (m_slot[i] == 3) begin
                m_w[i] = {m_bits[i][3], m_bits[i][2], m_bits[i][1], m_bits[i][0]};
                m_valid[i] = 1'b1;
                m_slot[i] = 0;
            end else begin
                m_slot[i] = m_slot[i] + 1;
            end
        end
    endfunction

    function automatic void chk(string name, logic [3:0] act, logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic void chk_model();
        chk("a.S",       {2'b00, S_a},      4'(m_slot[0]));
        chk("a.w",       w_a,               m_w[0]);
        chk("a.valid",   {3'b000, valid_a},   {3'b000, m_valid[0]});
        chk("a.realign", {3'b000, realign_a}, {3'b000, m_realign[0]});
        chk("b.S",       {2'b00, S_b},      4'(m_slot[1]));
        chk("b.w",       w_b,               m_w[1]);
        chk("b.valid",   {3'b000, valid_b},   {3'b000, m_valid[1]});
        chk("b.realign", {3'b000, realign_b}, {3'b000, m_realign[1]});
    endfunction

    task automatic cycle(input bit e, input bit s, input bit f);
        en = e;
        sync = s;
        F = f;
        @(posedge clk);
        model_step(0, e, s, f);
        model_step(1, e, s, f);
        #1;
        chk_model();
    endtask

    typedef struct {
        bit         en;
        bit         sync;
        bit         f;
        logic [1:0] s;
        logic [3:0] w;
        bit         v;
        bit         r;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit e, input bit sy, input bit f,
                       input logic [1:0] s, input logic [3:0] wv, input bit v, input bit r);
        vec_t t;
        t.en = e; t.sync = sy; t.f = f; t.s = s; t.w = wv; t.v = v; t.r = r;
        tbl.push_back(t);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        en = 1'b0;
        sync = 1'b0;
        F = 1'b0;
        model_reset();

        // Frame 1,0,1,1
        add(1,0,1, 2'd1, 4'h0, 0,0);
        add(1,0,0, 2'd2, 4'h0, 0,0);
        add(1,0,1, 2'd3, 4'h0, 0,0);
        add(1,0,1, 2'd0, 4'b1101, 1,0);
        // Back-to-back 0,0,0,1 then 1,1,1,0
        add(1,0,0, 2'd1, 4'b1101, 0,0);
        add(1,0,0, 2'd2, 4'b1101, 0,0);
        add(1,0,0, 2'd3, 4'b1101, 0,0);
        add(1,0,1, 2'd0, 4'b1000, 1,0);
        add(1,0,1, 2'd1, 4'b1000, 0,0);
        add(1,0,1, 2'd2, 4'b1000, 0,0);
        add(1,0,1, 2'd3, 4'b1000, 0,0);
        add(1,0,0, 2'd0, 4'b0111, 1,0);
        // Frame 1,1,0,0 with a 2-cycle en gap; sync during the gap is ignored
        add(1,0,1, 2'd1, 4'b0111, 0,0);
        add(1,0,1, 2'd2, 4'b0111, 0,0);
        add(0,0,0, 2'd2, 4'b0111, 0,0);
        add(0,1,1, 2'd2, 4'b0111, 0,0);
        add(1,0,0, 2'd3, 4'b0111, 0,0);
        add(1,0,0, 2'd0, 4'b0011, 1,0);
        // Mid-frame sync after 2 bits, then 0,1,0
        add(1,0,1, 2'd1, 4'b0011, 0,0);
        add(1,0,1, 2'd2, 4'b0011, 0,0);
        add(1,1,1, 2'd1, 4'b0011, 0,1);
        add(1,0,0, 2'd2, 4'b0011, 0,0);
        add(1,0,1, 2'd3, 4'b0011, 0,0);
        add(1,0,0, 2'd0, 4'b0101, 1,0);
        // Sync at slot 3 suppresses the word, then sync with en=0
        add(1,0,1, 2'd1, 4'b0101, 0,0);
        add(1,0,0, 2'd2, 4'b0101, 0,0);
        add(1,0,1, 2'd3, 4'b0101, 0,0);
        add(1,1,1, 2'd1, 4'b0101, 0,1);
        add(0,1,0, 2'd1, 4'b0101, 0,0);
        add(1,0,1, 2'd2, 4'b0101, 0,0);
        add(1,0,0, 2'd3, 4'b0101, 0,0);
        add(1,0,1, 2'd0, 4'b1011, 1,0);
        // Redundant sync at slot 0, then valid drops even with en=0
        add(1,1,0, 2'd1, 4'b1011, 0,0);
        add(1,0,1, 2'd2, 4'b1011, 0,0);
        add(1,0,1, 2'd3, 4'b1011, 0,0);
        add(1,0,0, 2'd0, 4'b0110, 1,0);
        add(0,0,1, 2'd0, 4'b0110, 0,0);

        #1;
        chk("reset.S", {2'b00, S_a}, 4'd0);
        chk("reset.w", w_a, 4'd0);
        chk("reset.valid", {3'b000, valid_a}, 4'd0);
        chk("reset.realign", {3'b000, realign_a}, 4'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        foreach (tbl[i]) begin
            cycle(tbl[i].en, tbl[i].sync, tbl[i].f);
            chk($sformatf("vec%0d.S", i), {2'b00, S_a}, {2'b00, tbl[i].s});
            chk($sformatf("vec%0d.w", i), w_a, tbl[i].w);
            chk($sformatf("vec%0d.valid", i), {3'b000, valid_a}, {3'b000, tbl[i].v});
            chk($sformatf("vec%0d.realign", i), {3'b000, realign_a}, {3'b000, tbl[i].r});
        end

        // Async reset mid-frame: w=1010, slot=2
        cycle(1,0,0); cycle(1,0,1); cycle(1,0,0); cycle(1,0,1);
        chk("pre_rst.w", w_a, 4'b1010);
        cycle(1,0,1); cycle(1,0,1);
        chk("pre_rst.S", {2'b00, S_a}, 4'd2);
        #3 rst = 1'b1;
        #1;
        chk("arst.S", {2'b00, S_a}, 4'd0);
        chk("arst.w", w_a, 4'd0);
        chk("arst.valid", {3'b000, valid_a}, 4'd0);
        chk("arst.b.w", w_b, 4'd0);
        model_reset();
        #2 rst = 1'b0;
        cycle(1,0,1); cycle(1,0,0); cycle(1,0,0); cycle(1,0,1);
        chk("post_rst.w", w_a, 4'b1001);
        chk("post_rst.valid", {3'b000, valid_a}, 4'd1);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(3, 0) != 0, $urandom_range(9, 0) == 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
